// File: rtl/multicycle_ctrl.sv
// Multicycle RISC-V control FSM: FETCH/DECODE/MEM/WB sequencing with memory timeout.
// Optional INSTR_COUNT_EN adds a 32-bit retired-instruction counter output.
module multicycle_ctrl #(
    parameter int MEM_TIMEOUT = 15
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       run,
    input  logic [6:0] opcode,
    input  logic       mem_ready,
    output logic [2:0] sel,
    output logic       IR_Write,
    output logic       ALUSrc,
    output logic       Mem_Read,
    output logic       Mem_Write,
    output logic       MemtoReg,
    output logic       RegWrite,
    output logic       Branch,
    output logic       PC_Write,
    output logic       done,
    output logic       illegal,
    output logic       mem_err
`ifdef INSTR_COUNT_EN
    ,
    output logic [31:0] instr_count
`endif
);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        FETCH  = 3'd1,
        DECODE = 3'd2,
        MEM    = 3'd3,
        WB     = 3'd4
    } state_t;

    localparam logic [6:0] OP_R  = 7'b0110011;
    localparam logic [6:0] OP_I  = 7'b0010011;
    localparam logic [6:0] OP_LD = 7'b0000011;
    localparam logic [6:0] OP_ST = 7'b0100011;
    localparam logic [6:0] OP_BR = 7'b1100011;
    localparam logic [3:0] TMO   = 4'(MEM_TIMEOUT);

    state_t     state;
    logic [6:0] op_q;
    logic [3:0] cnt;

    logic is_r, is_i, is_ld, is_st, is_br;
    logic mem_op, legal, timeout, fin;

    assign is_r   = (op_q == OP_R);
    assign is_i   = (op_q == OP_I);
    assign is_ld  = (op_q == OP_LD);
    assign is_st  = (op_q == OP_ST);
    assign is_br  = (op_q == OP_BR);
    assign mem_op = is_ld | is_st;
    assign legal  = opcode inside {OP_R, OP_I, OP_LD, OP_ST, OP_BR};

    assign timeout = (state == MEM) && mem_op && !mem_ready && (cnt == TMO);

    // Stores and branches retire in MEM; everything else retires in WB.
    assign fin = ((state == MEM) && ((is_st && mem_ready) || is_br))
               || (state == WB);

    assign sel      = state;
    assign done     = fin;
    assign PC_Write = fin;

    always_comb begin
        IR_Write  = 1'b0;
        ALUSrc    = 1'b0;
        Mem_Read  = 1'b0;
        Mem_Write = 1'b0;
        MemtoReg  = 1'b0;
        RegWrite  = 1'b0;
        Branch    = 1'b0;
        unique case (state)
            FETCH: IR_Write = 1'b1;
            MEM: begin
                ALUSrc    = is_ld | is_st | is_i;
                Mem_Read  = is_ld;
                Mem_Write = is_st;
                MemtoReg  = is_ld;
                Branch    = is_br;
            end
            WB: begin
                RegWrite = is_ld | is_r | is_i;
                MemtoReg = is_ld;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            op_q    <= 7'd0;
            cnt     <= 4'd0;
            illegal <= 1'b0;
            mem_err <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (run) begin
                        state   <= FETCH;
                        illegal <= 1'b0;
                        mem_err <= 1'b0;
                    end
                end
                FETCH: state <= DECODE;
                DECODE: begin
                    op_q <= opcode;
                    cnt  <= 4'd0;
                    if (legal) begin
                        state <= MEM;
                    end else begin
                        illegal <= 1'b1;
                        state   <= IDLE;
                    end
                end
                MEM: begin
                    if (timeout) begin
                        mem_err <= 1'b1;
                        state   <= IDLE;
                    end else if (mem_op && !mem_ready) begin
                        cnt <= cnt + 4'd1;
                    end else if (is_st || is_br) begin
                        state <= run ? FETCH : IDLE;
                    end else begin
                        state <= WB;
                    end
                end
                WB: state <= run ? FETCH : IDLE;
                default: state <= IDLE;
            endcase
        end
    end

`ifdef INSTR_COUNT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            instr_count <= 32'd0;
        end else if (fin) begin
            instr_count <= instr_count + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Scoreboard bench for multicycle_ctrl: per-cycle expected output vectors
// are queued when inputs are driven and compared on the falling edge.
module tb_multicycle_ctrl;

    localparam logic [6:0] OP_R  = 7'b0110011;
    localparam logic [6:0] OP_I  = 7'b0010011;
    localparam logic [6:0] OP_LD = 7'b0000011;
    localparam logic [6:0] OP_ST = 7'b0100011;
    localparam logic [6:0] OP_BR = 7'b1100011;
    localparam logic [6:0] OP_XX = 7'b1111111;

    localparam logic [7:0] Z   = 8'h00;
    localparam logic [7:0] IR  = 8'h80;
    localparam logic [7:0] ALU = 8'h40;
    localparam logic [7:0] MR  = 8'h20;
    localparam logic [7:0] MW  = 8'h10;
    localparam logic [7:0] M2R = 8'h08;
    localparam logic [7:0] RW  = 8'h04;
    localparam logic [7:0] BR  = 8'h02;
    localparam logic [7:0] PC  = 8'h01;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       run;
    logic [6:0] opcode;
    logic       mem_ready;
    logic [2:0] sel;
    logic       IR_Write, ALUSrc, Mem_Read, Mem_Write;
    logic       MemtoReg, RegWrite, Branch, PC_Write;
    logic       done, illegal, mem_err;
`ifdef INSTR_COUNT_EN
    logic [31:0] instr_count;
`endif

    multicycle_ctrl #(.MEM_TIMEOUT(15)) dut (
        .clk(clk),
        .rst_n(rst_n),
        .run(run),
        .opcode(opcode),
        .mem_ready(mem_ready),
        .sel(sel),
        .IR_Write(IR_Write),
        .ALUSrc(ALUSrc),
        .Mem_Read(Mem_Read),
        .Mem_Write(Mem_Write),
        .MemtoReg(MemtoReg),
        .RegWrite(RegWrite),
        .Branch(Branch),
        .PC_Write(PC_Write),
        .done(done),
        .illegal(illegal),
        .mem_err(mem_err)
`ifdef INSTR_COUNT_EN
        ,
        .instr_count(instr_count)
`endif
    );

    always #5 clk = ~clk;

    logic [13:0] vec;
    assign vec = {sel, IR_Write, ALUSrc, Mem_Read, Mem_Write, MemtoReg,
                  RegWrite, Branch, PC_Write, done, illegal, mem_err};

    int total = 0;
    int bad = 0;
    int n_done = 0;
    logic ill_m = 1'b0;
    logic me_m = 1'b0;

    logic [13:0] exq[$];
    string       tq[$];

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [13:0] e(input logic [2:0] s,
                                      input logic [7:0] st,
                                      input logic dn);
        return {s, st, dn, ill_m, me_m};
    endfunction

    task automatic step(input logic r, input logic [6:0] op, input logic mr,
                        input logic [13:0] ex, input string tag);
        run = r;
        opcode = op;
        mem_ready = mr;
        exq.push_back(ex);
        tq.push_back(tag);
        if (ex[2]) n_done++;
        @(posedge clk);
        #1;
    endtask

    always @(negedge clk) begin
        if (exq.size() > 0) chk(tq.pop_front(), {18'd0, vec}, {18'd0, exq.pop_front()});
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0;
        run = 1'b0;
        opcode = 7'd0;
        mem_ready = 1'b0;
        #3;
        chk("reset", {18'd0, vec}, 32'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        step(0, OP_LD, 1, e(0, Z, 0), "idle0");
        step(0, OP_LD, 1, e(0, Z, 0), "idle1");

        // LOAD, ready immediately; opcode input changes after DECODE
        step(1, OP_LD, 1, e(0, Z, 0), "ld_idle");
        step(1, OP_LD, 1, e(1, IR, 0), "ld_f");
        step(1, OP_LD, 1, e(2, Z, 0), "ld_d");
        step(1, OP_R, 1, e(3, ALU | MR | M2R, 0), "ld_m");
        step(0, OP_ST, 1, e(4, M2R | RW | PC, 1), "ld_wb");
        step(0, OP_ST, 0, e(0, Z, 0), "ld_end");

        // STORE with three wait cycles
        step(1, OP_ST, 0, e(0, Z, 0), "st_idle");
        step(1, OP_ST, 0, e(1, IR, 0), "st_f");
        step(1, OP_ST, 0, e(2, Z, 0), "st_d");
        for (int i = 0; i < 3; i++) step(1, OP_ST, 0, e(3, ALU | MW, 0), "st_wait");
        step(0, OP_ST, 1, e(3, ALU | MW | PC, 1), "st_fin");
        step(0, OP_ST, 0, e(0, Z, 0), "st_end");

        // LOAD timeout after 16 MEM cycles
        step(1, OP_LD, 0, e(0, Z, 0), "to_idle");
        step(1, OP_LD, 0, e(1, IR, 0), "to_f");
        step(1, OP_LD, 0, e(2, Z, 0), "to_d");
        for (int i = 0; i < 16; i++) step(1, OP_LD, 0, e(3, ALU | MR | M2R, 0), "to_wait");
        me_m = 1'b1;
        step(0, OP_LD, 0, e(0, Z, 0), "to_abort");
        step(1, OP_LD, 0, e(0, Z, 0), "to_restart");
        me_m = 1'b0;

        // LOAD ready exactly when counter hits the limit
        step(1, OP_LD, 0, e(1, IR, 0), "edge_f");
        step(1, OP_LD, 0, e(2, Z, 0), "edge_d");
        for (int i = 0; i < 15; i++) step(1, OP_LD, 0, e(3, ALU | MR | M2R, 0), "edge_wait");
        step(1, OP_LD, 1, e(3, ALU | MR | M2R, 0), "edge_rdy");
        step(0, OP_LD, 0, e(4, M2R | RW | PC, 1), "edge_wb");
        step(0, OP_LD, 0, e(0, Z, 0), "edge_end");

        // Illegal opcode
        step(1, OP_XX, 0, e(0, Z, 0), "ill_idle");
        step(1, OP_XX, 0, e(1, IR, 0), "ill_f");
        step(0, OP_XX, 1, e(2, Z, 0), "ill_d");
        ill_m = 1'b1;
        step(0, OP_XX, 1, e(0, Z, 0), "ill_flag");

        // R-type, run dropped in DECODE still completes
        step(1, OP_R, 0, e(0, Z, 0), "r_idle");
        ill_m = 1'b0;
        step(1, OP_R, 0, e(1, IR, 0), "r_f");
        step(0, OP_R, 0, e(2, Z, 0), "r_d");
        step(0, OP_R, 0, e(3, Z, 0), "r_m");
        step(0, OP_R, 0, e(4, RW | PC, 1), "r_wb");
        step(0, OP_R, 0, e(0, Z, 0), "r_end");

        // I-ALU ignores mem_ready, then five back-to-back branches
        step(1, OP_I, 0, e(0, Z, 0), "i_idle");
        step(1, OP_I, 0, e(1, IR, 0), "i_f");
        step(1, OP_I, 0, e(2, Z, 0), "i_d");
        step(1, OP_I, 0, e(3, ALU, 0), "i_m");
        step(1, OP_I, 0, e(4, RW | PC, 1), "i_wb");
        for (int i = 0; i < 5; i++) begin
            step(1, OP_BR, 0, e(1, IR, 0), "br_f");
            step(1, OP_BR, 0, e(2, Z, 0), "br_d");
            step(i < 4, OP_BR, 0, e(3, BR | PC, 1), "br_m");
        end
        step(0, OP_BR, 0, e(0, Z, 0), "br_end");

        // Asynchronous reset in the middle of a LOAD
        step(1, OP_LD, 0, e(0, Z, 0), "ar_idle");
        step(1, OP_LD, 0, e(1, IR, 0), "ar_f");
        step(1, OP_LD, 0, e(2, Z, 0), "ar_d");
        run = 1'b1;
        mem_ready = 1'b0;
        #2;
        chk("ar_mem", {18'd0, vec}, {18'd0, e(3, ALU | MR | M2R, 0)});
`ifdef INSTR_COUNT_EN
        chk("icnt", instr_count, n_done);
`endif
        rst_n = 1'b0;
        #1;
        chk("ar_zero", {18'd0, vec}, 32'd0);
`ifdef INSTR_COUNT_EN
        chk("icnt_rst", instr_count, 32'd0);
`endif
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        run = 1'b0;
        step(0, OP_LD, 0, e(0, Z, 0), "ar_after");
        step(1, OP_LD, 0, e(0, Z, 0), "ar_idle2");
        step(0, OP_LD, 0, e(1, IR, 0), "ar_f2");

        if (exq.size() != 0) begin
            bad++;
            $display("FAIL queue: %0d entries left, 0 required", exq.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
